// File: rtl/irqc_pkg.sv
// Shared types and limits for the external interrupt controller.
package irqc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irqc_state_t;

   localparam int IRQC_MAX_SRC = 16;

endpackage

// File: rtl/irqc_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
module irqc_prio_enc
   import irqc_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   output logic               valid,
   output logic [ID_W-1:0]    id
);

   // Scanning downward lets the lowest index overwrite any higher one.
   always_comb begin
      valid = 1'b0;
      id    = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            id    = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: edge latch, mask, fixed priority, single outstanding request.
// Define IRQC_SYNC_EN to place a 2-flop synchronizer on every irq_in line.
module ext_irq_ctrl
   import irqc_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = $clog2(NUM_SRC)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic [NUM_SRC-1:0] irq_mask,
   input  logic               ExtIAck,
   input  logic               ERet,
   output logic               ExtIRQ,
   output logic [ID_W-1:0]    irq_id,
   output logic [NUM_SRC-1:0] irq_pending,
   output logic               busy
);

   irqc_state_t        state;
   logic [NUM_SRC-1:0] irq_s;
   logic [NUM_SRC-1:0] irq_prev;
   logic [NUM_SRC-1:0] irq_edge;
   logic [NUM_SRC-1:0] ack_clr;
   logic               win_valid;
   logic [ID_W-1:0]    win_id;

`ifdef IRQC_SYNC_EN
   logic [NUM_SRC-1:0] sync_p0;
   logic [NUM_SRC-1:0] sync_p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= irq_in;
         sync_p1 <= sync_p0;
      end
   end

   assign irq_s = sync_p1;
`else
   assign irq_s = irq_in;
`endif

   assign irq_edge = irq_s & ~irq_prev;

   always_comb begin
      ack_clr = '0;
      if (state == REQ && ExtIAck) ack_clr[irq_id] = 1'b1;
   end

   irqc_prio_enc #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_prio (
      .req   (irq_pending & irq_mask),
      .valid (win_valid),
      .id    (win_id)
   );

   // A new edge on the source being acknowledged survives the clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_prev    <= '0;
         irq_pending <= '0;
      end else begin
         irq_prev    <= irq_s;
         irq_pending <= (irq_pending & ~ack_clr) | irq_edge;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         ExtIRQ <= 1'b0;
         irq_id <= '0;
         busy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_valid) begin
                  state  <= REQ;
                  ExtIRQ <= 1'b1;
                  irq_id <= win_id;
                  busy   <= 1'b1;
               end
            end
            REQ: begin
               if (ExtIAck) begin
                  state  <= SERVICE;
                  ExtIRQ <= 1'b0;
               end
            end
            SERVICE: begin
               if (ERet) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               ExtIRQ <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed bench for ext_irq_ctrl with hand-computed expectations per scenario.
module tb_ext_irq_ctrl;

`ifdef IRQC_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] irq_in;
   logic [3:0] irq_mask;
   logic       ExtIAck;
   logic       ERet;
   logic       ExtIRQ;
   logic [1:0] irq_id;
   logic [3:0] irq_pending;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   ext_irq_ctrl #(.NUM_SRC(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .irq_in      (irq_in),
      .irq_mask    (irq_mask),
      .ExtIAck     (ExtIAck),
      .ERet        (ERet),
      .ExtIRQ      (ExtIRQ),
      .irq_id      (irq_id),
      .irq_pending (irq_pending),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      irq_in  = '0;
      ExtIAck = 1'b0;
      ERet    = 1'b0;
      irq_mask = 4'hF;
      step(2);
      reset = 1'b0;
      step(1);
   endtask

   task automatic ack_and_return();
      ExtIAck = 1'b1; step(1); ExtIAck = 1'b0;
      ERet = 1'b1; step(1); ERet = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; irq_in = 4'hF; irq_mask = 4'hF; ExtIAck = 1'b0; ERet = 1'b0;
      step(3);
      n_cmp++;
      if ({ExtIRQ, irq_id, irq_pending, busy} !== 8'h00) begin
         n_err++; $display("FAIL reset_outputs got=%h exp=00", {ExtIRQ, irq_id, irq_pending, busy});
      end
      reset = 1'b0;
      step(1 + SL);
      n_cmp++;
      if (irq_pending !== 4'hF || ExtIRQ !== 1'b0) begin
         n_err++; $display("FAIL reset_release_pending got=%b/%b exp=1111/0", irq_pending, ExtIRQ);
      end
      step(1);
      n_cmp++;
      if (ExtIRQ !== 1'b1 || irq_id !== 2'd0 || busy !== 1'b1) begin
         n_err++; $display("FAIL reset_release_req got=%b/%0d/%b exp=1/0/1", ExtIRQ, irq_id, busy);
      end
   endtask

   task automatic test_basic();
      do_reset();
      irq_in = 4'b0100; step(1); irq_in = 4'b0000;
      step(SL);
      n_cmp++;
      if (irq_pending !== 4'b0100 || ExtIRQ !== 1'b0) begin
         n_err++; $display("FAIL basic_pending got=%b/%b exp=0100/0", irq_pending, ExtIRQ);
      end
      step(1);
      n_cmp++;
      if (ExtIRQ !== 1'b1 || irq_id !== 2'd2 || busy !== 1'b1) begin
         n_err++; $display("FAIL basic_req got=%b/%0d/%b exp=1/2/1", ExtIRQ, irq_id, busy);
      end
      ExtIAck = 1'b1; step(1); ExtIAck = 1'b0;
      n_cmp++;
      if (ExtIRQ !== 1'b0 || irq_pending !== 4'b0000 || busy !== 1'b1 || irq_id !== 2'd2) begin
         n_err++; $display("FAIL basic_ack got=%b/%b/%b/%0d exp=0/0000/1/2", ExtIRQ, irq_pending, busy, irq_id);
      end
      step(2);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL basic_service_hold got=%b exp=1", busy);
      end
      ERet = 1'b1; step(1); ERet = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || ExtIRQ !== 1'b0) begin
         n_err++; $display("FAIL basic_eret got=%b/%b exp=0/0", busy, ExtIRQ);
      end
   endtask

   task automatic test_priority();
      do_reset();
      irq_in = 4'b1010; step(1); irq_in = 4'b0000;
      step(SL + 1);
      n_cmp++;
      if (ExtIRQ !== 1'b1 || irq_id !== 2'd1) begin
         n_err++; $display("FAIL prio_first got=%b/%0d exp=1/1", ExtIRQ, irq_id);
      end
      irq_in = 4'b0001; step(1); irq_in = 4'b0000;
      step(SL + 1);
      n_cmp++;
      if (ExtIRQ !== 1'b1 || irq_id !== 2'd1 || irq_pending !== 4'b1011) begin
         n_err++; $display("FAIL prio_hold got=%b/%0d/%b exp=1/1/1011", ExtIRQ, irq_id, irq_pending);
      end
      ack_and_return();
      n_cmp++;
      if (ExtIRQ !== 1'b0 || irq_pending !== 4'b1001) begin
         n_err++; $display("FAIL prio_idle_gap got=%b/%b exp=0/1001", ExtIRQ, irq_pending);
      end
      step(1);
      n_cmp++;
      if (ExtIRQ !== 1'b1 || irq_id !== 2'd0) begin
         n_err++; $display("FAIL prio_second got=%b/%0d exp=1/0", ExtIRQ, irq_id);
      end
      ack_and_return();
      step(1);
      n_cmp++;
      if (ExtIRQ !== 1'b1 || irq_id !== 2'd3) begin
         n_err++; $display("FAIL prio_third got=%b/%0d exp=1/3", ExtIRQ, irq_id);
      end
      ack_and_return();
      n_cmp++;
      if (irq_pending !== 4'b0000 || busy !== 1'b0) begin
         n_err++; $display("FAIL prio_drained got=%b/%b exp=0000/0", irq_pending, busy);
      end
   endtask

   task automatic test_masking();
      do_reset();
      irq_mask = 4'b1110;
      irq_in = 4'b0001; step(1); irq_in = 4'b0000;
      step(SL + 2);
      n_cmp++;
      if (irq_pending !== 4'b0001 || ExtIRQ !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL mask_blocked got=%b/%b/%b exp=0001/0/0", irq_pending, ExtIRQ, busy);
      end
      ExtIAck = 1'b1; ERet = 1'b1; step(1); ExtIAck = 1'b0; ERet = 1'b0;
      n_cmp++;
      if (irq_pending !== 4'b0001 || ExtIRQ !== 1'b0) begin
         n_err++; $display("FAIL mask_idle_ack_ignored got=%b/%b exp=0001/0", irq_pending, ExtIRQ);
      end
      irq_mask = 4'b1111; step(1);
      n_cmp++;
      if (ExtIRQ !== 1'b1 || irq_id !== 2'd0) begin
         n_err++; $display("FAIL mask_enable got=%b/%0d exp=1/0", ExtIRQ, irq_id);
      end
      irq_mask = 4'b0000; ERet = 1'b1; step(2); ERet = 1'b0;
      n_cmp++;
      if (ExtIRQ !== 1'b1 || irq_id !== 2'd0 || busy !== 1'b1) begin
         n_err++; $display("FAIL mask_req_hold got=%b/%0d/%b exp=1/0/1", ExtIRQ, irq_id, busy);
      end
      irq_mask = 4'b1111;
      ack_and_return();
   endtask

   task automatic test_collision();
      do_reset();
      irq_in = 4'b0010; step(1); irq_in = 4'b0000;
      step(SL + 1);
      n_cmp++;
      if (ExtIRQ !== 1'b1 || irq_id !== 2'd1) begin
         n_err++; $display("FAIL coll_req got=%b/%0d exp=1/1", ExtIRQ, irq_id);
      end
      irq_in = 4'b0010;
      step(SL);
      ExtIAck = 1'b1; step(1); ExtIAck = 1'b0; irq_in = 4'b0000;
      n_cmp++;
      if (irq_pending !== 4'b0010 || ExtIRQ !== 1'b0 || busy !== 1'b1) begin
         n_err++; $display("FAIL coll_set_wins got=%b/%b/%b exp=0010/0/1", irq_pending, ExtIRQ, busy);
      end
      ERet = 1'b1; step(1); ERet = 1'b0;
      step(1);
      n_cmp++;
      if (ExtIRQ !== 1'b1 || irq_id !== 2'd1) begin
         n_err++; $display("FAIL coll_reserve got=%b/%0d exp=1/1", ExtIRQ, irq_id);
      end
      ack_and_return();
   endtask

   task automatic test_reset_mid_service();
      do_reset();
      irq_in = 4'b0100; step(1); irq_in = 4'b0000;
      step(SL + 1);
      ExtIAck = 1'b1; step(1); ExtIAck = 1'b0;
      irq_in = 4'b1000; step(1); irq_in = 4'b0000;
      step(SL);
      n_cmp++;
      if (busy !== 1'b1 || irq_pending !== 4'b1000) begin
         n_err++; $display("FAIL rst_mid_setup got=%b/%b exp=1/1000", busy, irq_pending);
      end
      reset = 1'b1; step(1); reset = 1'b0;
      n_cmp++;
      if ({ExtIRQ, irq_id, irq_pending, busy} !== 8'h00) begin
         n_err++; $display("FAIL rst_mid_cleared got=%h exp=00", {ExtIRQ, irq_id, irq_pending, busy});
      end
      ERet = 1'b1; step(1); ERet = 1'b0;
      step(3);
      n_cmp++;
      if (ExtIRQ !== 1'b0 || busy !== 1'b0 || irq_pending !== 4'b0000) begin
         n_err++; $display("FAIL rst_mid_eret_noop got=%b/%b/%b exp=0/0/0000", ExtIRQ, busy, irq_pending);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_masking();
      test_collision();
      test_reset_mid_service();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ext_irq_ctrl.md
Name: ext_irq_ctrl

Overview:
- External interrupt controller sitting directly upstream of the processor's control unit.
- Latches edge events from NUM_SRC external lines, applies a mask and fixed priority, and drives ExtIRQ into the control unit.
- Retires the request on ExtIAck, then blocks further requests until the handler executes ERET.
- Exports the served source index so the exception path can record it alongside EStatus.

Parameters:
- NUM_SRC, 4, number of external interrupt lines (2..16).
- ID_W, $clog2(NUM_SRC), width of irq_id.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- irq_in  in  NUM_SRC  raw interrupt lines, rising-edge sensitive
- irq_mask  in  NUM_SRC  1 = source enabled; gates arbitration only, never latching
- ExtIAck  in  1  acknowledge from control unit (ExcAck && ExtIRQ)
- ERet  in  1  ERET instruction executing this cycle
- ExtIRQ  out  1  interrupt request to control unit (registered)
- irq_id  out  ID_W  index of the source being requested/served
- irq_pending  out  NUM_SRC  pending latch contents
- busy  out  1  high in REQ and SERVICE

Behaviour:
- Reset values, taken at the clock edge with reset=1: state=IDLE, ExtIRQ=0, irq_id=0, irq_pending=0, busy=0, internal irq_prev=0. Reset overrides every other input and aborts any state.
- A line already high when reset is released is seen as an edge on the first active cycle.
- Edge detect: edge[i] = irq_in[i] & ~irq_prev[i]. irq_prev is updated every cycle.
- Pending latch: pending[i] sets on edge[i] and clears only when source i is acknowledged. When set and clear coincide for the same source, set wins.
- Pending accumulates in every state. Repeated edges on a pending source collapse to one.
- Priority: lowest index among (pending & irq_mask) wins (fixed priority).
- FSM IDLE: if any (pending & mask) bit is set, go to REQ at the next edge. On that same edge, latch irq_id = winner and set ExtIRQ=1.
- FSM REQ: ExtIRQ=1 and irq_id are held stable.
  - Mask changes or higher-priority arrivals neither withdraw nor change the request.
  - On an edge with ExtIAck=1: go to SERVICE, set ExtIRQ=0, clear pending[irq_id].
- FSM SERVICE: ExtIRQ=0, busy=1, irq_id held.
  - On an edge with ERet=1: go to IDLE.
  - Arbitration resumes from IDLE on the following cycle.
- ERet in IDLE or REQ is ignored. ExtIAck outside REQ is ignored.
- Latency (no sync feature): irq_in rises before edge E0 → pending visible after E0 → ExtIRQ high after E1.
  - Minimum one idle cycle between ERet and the next ExtIRQ.
- Single request outstanding at all times; no nesting.

Optional Feature:
- Macro: IRQC_SYNC_EN.
- With the macro: each irq_in passes through a 2-flop synchronizer, reset to 0, before edge detection. Every latency above grows by exactly 2 cycles, and pulses shorter than 1 cycle may be lost.
- Without the macro: irq_in feeds edge detection directly and the inputs are required to be synchronous to clk.

Decomposition:
- Package irqc_pkg holds:
  - state enum irqc_state_t {IDLE, REQ, SERVICE}, 2 bits;
  - localparam IRQC_MAX_SRC = 16.
- Sub-module irqc_prio_enc is combinational: it takes NUM_SRC request bits and returns valid plus the lowest set index (ID_W bits).
- FSM, pending latch and edge detect stay in ext_irq_ctrl.

Test Plan:
- Reset hold: irq_in=4'b1111 held in reset for 3 cycles, then released. Outputs are 0 during reset. After release, pending=4'b1111 after one edge and ExtIRQ=1 with irq_id=0 after the next.
- Basic service: mask=4'b1111, pulse irq_in[2] for 1 cycle.
  - ExtIRQ rises 2 edges later with irq_id=2.
  - ExtIAck=1 for 1 cycle → ExtIRQ=0, pending[2]=0, busy=1.
  - ERet=1 → busy=0 next edge.
- Priority and hold: pending sources 3 and 1 → irq_id=1. Source 0 raised during REQ: irq_id stays 1. After ack+ERet, source 0 is served next, then source 3.
- Masking: mask=4'b1110, edge on irq_in[0] → pending[0]=1 and ExtIRQ stays 0. Set mask[0]=1 → ExtIRQ rises next edge with irq_id=0.
- Collision: new edge on irq_in[1] in the same cycle as ExtIAck for id 1 → pending[1] remains 1; re-served after ERet.
- Reset mid-SERVICE: reset=1 → state IDLE, pending cleared, ERet afterwards has no effect. Under IRQC_SYNC_EN, repeat the basic service case and check ExtIRQ rises 4 edges after the pulse.
